register_skid: RTL and testbench
================================

# register_skid

Elastic two-entry pipeline register with a valid/ready handshake on both sides. It is the flow-controlled counterpart to the plain pipeline register. Where a plain register captures every cycle unconditionally, this block accepts a word only when it has room, presents it downstream, and absorbs one word of backpressure in a skid slot. It sits on datapath boundaries between Genesys compute and buffer stages where the consumer can stall. It sustains full throughput with registered ready and registered data outputs.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- STALL_CNT_W, 16, width of the stall counter (used only when the counter is compiled in)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately, and release is sampled on clk
- s_valid  in  1  upstream word valid
- s_ready  out  1  block can accept a word; registered
- s_data  in  WIDTH  upstream word
- m_valid  out  1  downstream word valid; registered
- m_ready  in  1  downstream accepts a word
- m_data  out  WIDTH  downstream word; registered
- occupancy  out  2  words held: 0, 1 or 2
- stall_count  out  STALL_CNT_W  saturating stall counter; port exists only with REGISTER_SKID_STALL_CNT_EN

## Operation
- Transfer rule: a side transfers when valid and ready are both 1 at a rising edge.
- Storage: main register (drives m_data) and skid register.
- States:
  - EMPTY: occupancy 0, m_valid 0, s_ready 1.
  - BUSY: occupancy 1, m_valid 1, s_ready 1.
  - FULL: occupancy 2, m_valid 1, s_ready 0.
- EMPTY:
  - s_valid -> BUSY, main <= s_data.
  - otherwise stay.
- BUSY:
  - s_valid & m_ready -> BUSY, main <= s_data.
  - s_valid & !m_ready -> FULL, skid <= s_data.
  - !s_valid & m_ready -> EMPTY.
  - otherwise stay.
- FULL:
  - m_ready -> BUSY, main <= skid. s_valid is ignored because s_ready is 0.
  - otherwise stay.
- While m_valid & !m_ready, m_data and m_valid are held stable.
- Ordering is strict FIFO. Words are never dropped or duplicated.
- s_data is sampled only on an upstream transfer. Contents are don't-care otherwise.
- Upstream must hold s_valid/s_data while s_ready is 0 (standard valid/ready rule). The block does not check this.

## Timing
- Reset asserted:
  - state EMPTY
  - m_valid 0, m_data 0, skid 0
  - occupancy 0
  - s_ready 0
  - stall_count 0
- s_ready goes to 1 at the first rising edge after reset is released. No word is accepted on that edge.
- Latency: a word accepted at edge N is on m_data with m_valid=1 after edge N.
- Throughput: one word per cycle in steady state with m_ready held at 1.
- s_ready is a pure register output with no combinational path from m_ready.
- s_ready falls in the cycle after the edge that fills the skid slot. It rises in the cycle after the edge that drains the slot.
- Simultaneous events:
  - BUSY with both sides transferring: occupancy stays 1 and main takes the new word.
  - FULL with m_ready: the skid word moves to main. Upstream cannot enter on the same edge.
- Reset mid-operation: held words are discarded asynchronously, with no partial output.

## Configuration
- REGISTER_SKID_STALL_CNT_EN defined:
  - stall_count port present.
  - Increments on every edge where m_valid=1 and m_ready=0.
  - Saturates at 2^STALL_CNT_W-1.
  - Cleared only by reset.
- Undefined: no counter logic and no stall_count port. All other behaviour is identical.

## Test plan
- Reset, then release: s_ready=0 on the first cycle and 1 after the first edge. m_valid=0 and occupancy=0 throughout.
- Stream 0x01..0x10 with s_valid and m_ready held at 1 -> m_data equals 0x01..0x10 in order, one per cycle, each 1 cycle after acceptance. occupancy stays 1.
- Send 0xA5 then 0x5A with m_ready=0 -> occupancy=2 and s_ready=0. m_data holds 0xA5. Raise m_ready -> 0xA5 then 0x5A are delivered, and s_ready returns to 1.
- Random s_valid/m_ready with a 50% duty cycle, 10k words -> scoreboard shows no loss, duplication or reordering. m_data is stable whenever m_valid & !m_ready.
- Assert reset while FULL (0x11, 0x22) -> m_valid, occupancy and m_data drop to 0 immediately. After release, nothing is output.
- With REGISTER_SKID_STALL_CNT_EN and STALL_CNT_W=4: hold m_ready=0 with a word held for 20 cycles -> stall_count reads 15 (saturated). Reset -> 0.

Source files
------------

// File: rtl/register_skid.sv
// register_skid: two-entry elastic pipeline register (main + skid slot)
// with valid/ready on both sides. s_ready, m_valid and m_data are all
// driven straight from flops, so there is no combinational path from
// m_ready back to s_ready.
// Optional feature macro: REGISTER_SKID_STALL_CNT_EN adds a saturating
// stall counter and the stall_count port.
module register_skid #(
  parameter int WIDTH       = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
`ifdef REGISTER_SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q, s_ready_d;
  logic             up_xfer;

  // s_ready has its own flop so it can sit at 0 during reset and only
  // come up on the first edge after release.
  assign up_xfer = s_valid & s_ready_q;

  // State, data and ready registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Next-state and datapath: the skid slot only fills when main is
  // occupied and downstream stalls; it drains into main on m_ready.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          state_d = BUSY;
          main_d  = s_data;
        end
      end
      BUSY: begin
        if (up_xfer && m_ready) begin
          main_d = s_data;
        end else if (up_xfer && !m_ready) begin
          state_d = FULL;
          skid_d  = s_data;
        end else if (!up_xfer && m_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (m_ready) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    s_ready_d = (state_d != FULL);
  end

  // Outputs decoded from registered state only.
  always_comb begin
    m_valid   = (state_q != EMPTY);
    occupancy = state_q;
    m_data    = main_q;
    s_ready   = s_ready_q;
  end

`ifdef REGISTER_SKID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Saturating count of edges where a word is offered but not taken.
  always_comb begin
    stall_d = stall_q;
    if (m_valid && !m_ready && (stall_q != {STALL_CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_register_skid.sv
// Directed + scoreboarded bench for register_skid. Inputs are driven and
// outputs sampled on the falling edge; the DUT updates on the rising edge.
module tb_register_skid;

  localparam int WIDTH = 8;
`ifdef REGISTER_SKID_STALL_CNT_EN
  localparam int SCW = 4;
`else
  localparam int SCW = 16;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       occupancy;
`ifdef REGISTER_SKID_STALL_CNT_EN
  logic [SCW-1:0]   stall_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  register_skid #(.WIDTH(WIDTH), .STALL_CNT_W(SCW)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
`ifdef REGISTER_SKID_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one full cycle: rising edge, then land on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    step();
  endtask

  initial begin
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] nxt, exp_w, prev_data;
    logic             prev_hold, offered;
    int               delivered, cyc;

    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // ---- reset and release ----
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_data", m_data, 0);
    s_valid = 1'b1; s_data = 8'hEE;   // must not be taken on the first edge
    #2 reset = 1'b1;
    chk("rel_s_ready_pre", s_ready, 0);
    step();
    chk("rel_s_ready_post", s_ready, 1);
    chk("rel_m_valid", m_valid, 0);
    chk("rel_occ", occupancy, 0);
    s_valid = 1'b0;
    step();
    chk("rel_still_empty", m_valid, 0);

    // ---- full-rate stream 0x01..0x10 ----
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      s_valid = 1'b1; s_data = WIDTH'(k);
      step();
      chk("stream_data", m_data, k);
      chk("stream_valid", m_valid, 1);
      chk("stream_occ", occupancy, 1);
      chk("stream_s_ready", s_ready, 1);
    end
    s_valid = 1'b0;
    step();
    chk("stream_done_empty", m_valid, 0);

    // ---- backpressure into the skid slot ----
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    chk("bp_occ1", occupancy, 1);
    s_data = 8'h5A;
    step();
    chk("bp_occ2", occupancy, 2);
    chk("bp_s_ready0", s_ready, 0);
    chk("bp_hold_a5", m_data, 8'hA5);
    s_valid = 1'b0;
    step();
    chk("bp_still_a5", m_data, 8'hA5);
    chk("bp_still_full", occupancy, 2);
    m_ready = 1'b1;   // A5 leaves on this edge, 5A moves to main
    step();
    chk("bp_5a", m_data, 8'h5A);
    chk("bp_5a_valid", m_valid, 1);
    chk("bp_s_ready1", s_ready, 1);
    chk("bp_occ_back1", occupancy, 1);
    step();
    chk("bp_empty", m_valid, 0);

    // ---- random traffic with scoreboard ----
    nxt = 8'h00; delivered = 0; cyc = 0;
    prev_hold = 1'b0; prev_data = '0; offered = 1'b0;
    while (delivered < 10000 && cyc < 80000) begin
      cyc++;
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_s_ready", s_ready, (q.size() < 2) ? 1 : 0);
      if (prev_hold) begin
        chk("rnd_hold_valid", m_valid, 1);
        chk("rnd_hold_data", m_data, prev_data);
      end
      m_ready = 1'($urandom_range(0, 1));
      if (!(offered && !s_ready)) s_valid = 1'($urandom_range(0, 1));
      s_data = nxt;
      if (m_valid && m_ready) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 8'hXX;
        chk("rnd_word", m_data, exp_w);
        delivered++;
      end
      if (s_valid && s_ready) begin
        q.push_back(nxt);
        nxt = nxt + 1'b1;
      end
      offered   = s_valid;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      step();
    end
    chk("rnd_delivered", delivered, 10000);
    drain();
    chk("rnd_drained", m_valid, 0);

    // ---- reset while FULL ----
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h11;
    step();
    s_data = 8'h22;
    step();
    chk("rf_full", occupancy, 2);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rf_m_valid", m_valid, 0);
    chk("rf_occ", occupancy, 0);
    chk("rf_m_data", m_data, 0);
    chk("rf_s_ready", s_ready, 0);
    @(negedge clk);
    reset = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rf_no_output", m_valid, 0);
    end

`ifdef REGISTER_SKID_STALL_CNT_EN
    // ---- stall counter saturation ----
    reset = 1'b0;
    #1 chk("sc_rst", stall_count, 0);
    @(negedge clk);
    reset = 1'b1; m_ready = 1'b0;
    step();
    s_valid = 1'b1; s_data = 8'h77;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("sc_sat", stall_count, 15);
    reset = 1'b0;
    #1 chk("sc_clear", stall_count, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
